bp_fe_bht_update_queue: RTL and testbench

// - Buffers resolved-branch updates from the backend and drains them into the write port of the global-history BHT.

---
 rtl/bp_fe_bht_update_queue.sv | 106 ++++++++++
 tb/tb_bp_fe_bht_update_queue.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bp_fe_bht_update_queue.sv
// Update queue in front of the global-history BHT write port. Resolved-branch
// updates wait here while BHT reads own the port, and drain in FIFO order.
module bp_fe_bht_update_queue #(
    parameter int global_history_length_p = 14,
    parameter int depth_p                 = 4,
    parameter int ctr_width_p             = 16
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               flush_i,
    input  logic                               upd_v_i,
    output logic                               upd_ready_o,
    input  logic [global_history_length_p-1:0] upd_history_i,
    input  logic                               upd_actual_i,
    input  logic                               upd_predicted_i,
    input  logic                               bht_r_v_i,
    output logic                               w_v_o,
    output logic [global_history_length_p-1:0] history_w_o,
    output logic                               actual_o,
    output logic                               correct_o,
    output logic [ctr_width_p-1:0]             mispredict_cnt_o,
    output logic                               overflow_o
);

    localparam int AW = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_W = PW'(depth_p);

    typedef struct packed {
        logic [global_history_length_p-1:0] history;
        logic                               actual;
        logic                               correct;
    } entry_t;

    entry_t                 mem_q [depth_p];
    entry_t                 head;
    logic [PW-1:0]          wptr_q, wptr_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [ctr_width_p-1:0] cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   full, empty, enq, deq;

    // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign enq  = upd_v_i & ~full & ~flush_i;
    assign deq  = ~empty & ~bht_r_v_i & ~flush_i;
    assign head = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q + PW'(enq);
        rptr_d = rptr_q + PW'(deq);
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end
        cnt_d = cnt_q;
        if (deq && !head.correct && (cnt_q != {ctr_width_p{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
        ovf_d = ovf_q | (upd_v_i & full);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q[AW-1:0]] <= '{history: upd_history_i,
                                       actual:  upd_actual_i,
                                       correct: ~(upd_actual_i ^ upd_predicted_i)};
        end
    end

    assign upd_ready_o      = ~full;
    assign w_v_o            = deq;
    assign history_w_o      = head.history;
    assign actual_o         = head.actual;
    assign correct_o        = head.correct;
    assign mispredict_cnt_o = cnt_q;
    assign overflow_o       = ovf_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert ((depth_p & (depth_p - 1)) == 0) else $error("depth_p not a power of 2");
            assert (!(enq && full)) else $error("enqueue while full");
            assert (PW'(wptr_q - rptr_q) <= DEPTH_W) else $error("pointer difference exceeds depth");
        end
    end
`endif

endmodule

// File: tb/tb_bp_fe_bht_update_queue.sv
// Randomised bench for the BHT update queue: the driver keeps a queue model of
// pending writes, and a negedge monitor pops it whenever a write is expected.
module tb_bp_fe_bht_update_queue;

    localparam int GHL   = 14;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0, upd_v = 1'b0, act = 1'b0, pred = 1'b0, bht_r = 1'b0;
    logic [GHL-1:0] hist = '0;

    logic           ready_a, wv_a, act_a, cor_a, ovf_a;
    logic [GHL-1:0] hist_a;
    logic [15:0]    cnt_a;
    logic           ready_b, wv_b, act_b, cor_b, ovf_b;
    logic [GHL-1:0] hist_b;
    logic [1:0]     cnt_b;

    bp_fe_bht_update_queue #(.global_history_length_p(GHL), .depth_p(DEPTH), .ctr_width_p(16)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .flush_i(flush), .upd_v_i(upd_v), .upd_ready_o(ready_a),
        .upd_history_i(hist), .upd_actual_i(act), .upd_predicted_i(pred), .bht_r_v_i(bht_r),
        .w_v_o(wv_a), .history_w_o(hist_a), .actual_o(act_a), .correct_o(cor_a),
        .mispredict_cnt_o(cnt_a), .overflow_o(ovf_a));

    // Narrow-counter copy on the same stimulus, to exercise saturation.
    bp_fe_bht_update_queue #(.global_history_length_p(GHL), .depth_p(DEPTH), .ctr_width_p(2)) dut_sat (
        .clk_i(clk), .reset_n_i(rst_n), .flush_i(flush), .upd_v_i(upd_v), .upd_ready_o(ready_b),
        .upd_history_i(hist), .upd_actual_i(act), .upd_predicted_i(pred), .bht_r_v_i(bht_r),
        .w_v_o(wv_b), .history_w_o(hist_b), .actual_o(act_b), .correct_o(cor_b),
        .mispredict_cnt_o(cnt_b), .overflow_o(ovf_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [GHL-1:0] h;
        logic           a;
        logic           c;
    } exp_t;

    exp_t sb[$];
    exp_t pend_e;
    exp_t mon_e;
    bit   pend_v, pend_f, pend_ovf;
    bit   m_ovf;
    int   raw_cnt;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Apply the previous cycle's effects to the model, then drive this cycle.
    task automatic cycle(input bit v, input logic [GHL-1:0] h, input bit a, input bit p,
                         input bit r, input bit f);
        @(posedge clk);
        if (pend_f) sb.delete();
        if (pend_v) sb.push_back(pend_e);
        if (pend_ovf) m_ovf = 1'b1;
        #1;
        upd_v = v; hist = h; act = a; pred = p; bht_r = r; flush = f;
        pend_v   = v && !f && (sb.size() < DEPTH);
        pend_f   = f;
        pend_ovf = v && (sb.size() >= DEPTH);
        pend_e   = '{h: h, a: a, c: (a == p)};
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, r, 1'b0);
    endtask

    // Reset lands mid-cycle; outputs are checked before any further clock edge.
    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_w_v", wv_a, 0);
        chk("rst_ready", ready_a, 1);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_cnt_sat", cnt_b, 0);
        chk("rst_ovf", ovf_a, 0);
        sb.delete();
        pend_v = 0; pend_f = 0; pend_ovf = 0;
        m_ovf = 0; raw_cnt = 0;
        upd_v = 0; flush = 0; bht_r = 0; act = 0; pred = 0; hist = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            automatic bit exp_wv = (sb.size() > 0) && !bht_r && !flush;
            chk("ready", ready_a, sb.size() < DEPTH);
            chk("w_v", wv_a, exp_wv);
            chk("cnt", cnt_a, sat(raw_cnt, 65535));
            chk("cnt_sat", cnt_b, sat(raw_cnt, 3));
            chk("overflow", ovf_a, m_ovf);
            if (exp_wv) begin
                mon_e = sb.pop_front();
                chk("history_w", hist_a, mon_e.h);
                chk("actual", act_a, mon_e.a);
                chk("correct", cor_a, mon_e.c);
                if (!mon_e.c) raw_cnt++;
            end
        end
    end

    initial begin
        do_reset();

        // single correct update, visible one cycle later
        cycle(1, 14'h0A5, 1, 1, 0, 0);
        idle(3, 0);

        // fill behind a busy read port, then overflow and drain
        for (int i = 0; i < 5; i++) cycle(1, 14'(16'h100 + i), i[0], i[0], 1, 0);
        idle(2, 1);
        idle(6, 0);

        // 3 mispredicts + 1 correct, then 5 more mispredicts to saturate the narrow counter
        for (int i = 0; i < 4; i++) cycle(1, 14'(16'h200 + i), 1, (i == 3), 1, 0);
        idle(6, 0);
        for (int i = 0; i < 5; i++) cycle(1, 14'(16'h300 + i), 0, 1, 0, 0);
        idle(4, 0);

        // flush with a simultaneous offer
        for (int i = 0; i < 2; i++) cycle(1, 14'(16'h400 + i), 1, 0, 1, 0);
        cycle(1, 14'h3FF, 1, 1, 0, 1);
        idle(4, 0);

        // streaming with wrap-around
        for (int i = 0; i < 20; i++) cycle(1, 14'(16'h500 + i), i[1], i[2], 0, 0);
        idle(3, 0);

        // reset in the middle of a drain
        for (int i = 0; i < 3; i++) cycle(1, 14'(16'h600 + i), 1, 0, 1, 0);
        cycle(0, '0, 0, 0, 0, 0);
        do_reset();
        idle(5, 0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 99) < 60, 14'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5);
        end

        for (int i = 0; i < 20 && (sb.size() > 0 || pend_v); i++) idle(1, 0);
        idle(1, 0);
        chk("drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
